// File: rtl/q15_divider.sv
// Signed Q15 divider: res = trunc((a << 15) / b), saturated, via 79-step restoring division.
// Fixed 80-cycle latency from acceptance to done; divide-by-zero reports nan with a signed full-scale result.
module q15_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic        nan,
  output logic [63:0] res
);

  localparam logic [63:0] QMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] QMIN = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_nxt;
  logic [6:0]  cnt;
  logic [78:0] nq;     // dividend bits shift out the top, quotient bits shift in the bottom
  logic [63:0] rem;
  logic [63:0] d;
  logic        sgn, a_neg;

  logic [63:0] a_mag, b_mag;
  logic [64:0] rem_sh;
  logic [63:0] rem_sub;
  logic        ge;
  logic        q_hi;
  logic [63:0] res_nxt;

  always_comb begin
    a_mag   = a[63] ? (~a + 64'd1) : a;
    b_mag   = b[63] ? (~b + 64'd1) : b;
    rem_sh  = {rem, nq[78]};
    ge      = (rem_sh >= {1'b0, d});
    // when ge holds the true difference is below d, so the low 64 bits are exact
    rem_sub = rem_sh[63:0] - d;
  end

  // quotient post-processing: sign, saturation, divide-by-zero
  always_comb begin
    q_hi = |nq[78:64];
    if (d == 64'd0)
      res_nxt = a_neg ? QMIN : QMAX;
    else if (!sgn)
      res_nxt = (q_hi || nq[63]) ? QMAX : nq[63:0];
    else
      res_nxt = (q_hi || (nq[63] && |nq[62:0])) ? QMIN : (~nq[63:0] + 64'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == 7'd78) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 7'd0;
      nq    <= 79'd0;
      rem   <= 64'd0;
      d     <= 64'd0;
      sgn   <= 1'b0;
      a_neg <= 1'b0;
      done  <= 1'b0;
      nan   <= 1'b0;
      res   <= 64'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          nq    <= {a_mag, 15'd0};
          d     <= b_mag;
          rem   <= 64'd0;
          sgn   <= a[63] ^ b[63];
          a_neg <= a[63];
          cnt   <= 7'd0;
        end
        CALC: begin
          rem <= ge ? rem_sub : rem_sh[63:0];
          nq  <= {nq[77:0], ge};
          cnt <= cnt + 7'd1;
        end
        FIX: begin
          res  <= res_nxt;
          nan  <= (d == 64'd0);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_q15_divider.sv
// Directed-vector bench for q15_divider: results, latency, saturation, start masking, reset abort.
module tb_q15_divider;

  logic        clk, rst_n, start;
  logic [63:0] a, b;
  logic        busy, done, nan;
  logic [63:0] res;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  q15_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .nan(nan), .res(res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [63:0] av, input logic [63:0] bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_done();
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                    input logic [63:0] eres, input logic enan);
    accept(av, bv);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done();
    chk({tag, "_lat"}, 64'(cyc), 64'd80);
    chk({tag, "_res"}, res, eres);
    chk({tag, "_nan"}, 64'(nan), 64'(enan));
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int nd;
    rst_n = 1'b0; start = 1'b0; a = 64'd0; b = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_nan",  64'(nan),  64'd0);
    chk("rst_res",  res,       64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op("p1.5",  64'h18000,  64'h10000, 64'hC000, 1'b0);
    op("m1.5", -64'h18000,  64'h10000, 64'hFFFF_FFFF_FFFF_4000, 1'b0);
    op("third", 64'h1,      64'h3,     64'h2AAA, 1'b0);
    op("dz_pos", 64'h8000,  64'h0,     64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    op("dz_neg", -64'h8000, 64'h0,     64'h8000_0000_0000_0000, 1'b1);
    op("dz_zero", 64'h0,    64'h0,     64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    op("sat_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    op("min_neg1", 64'h8000_0000_0000_0000, -64'h8000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    op("min_pos1", 64'h8000_0000_0000_0000, 64'h8000, 64'h8000_0000_0000_0000, 1'b0);
    op("sat_neg", 64'h8000_0000_0000_0000, 64'h1, 64'h8000_0000_0000_0000, 1'b0);
    op("neg_neg", -64'h10000, -64'h4000, 64'h20000, 1'b0);

    // second start mid-operation with new operands is ignored
    accept(64'h18000, 64'h10000);
    repeat (10) begin @(posedge clk); #1; cyc++; end
    a = 64'h1; b = 64'h3; start = 1'b1;
    @(posedge clk); #1; cyc++;
    start = 1'b0; a = 64'h0; b = 64'h0;
    wait_done();
    chk("ign_lat", 64'(cyc), 64'd80);
    chk("ign_res", res, 64'hC000);
    chk("ign_nan", 64'(nan), 64'd0);

    // start held high: second operation accepted on the done cycle
    @(negedge clk);
    a = 64'h18000; b = 64'h10000; start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    @(negedge clk);
    a = 64'h1; b = 64'h3;
    wait_done();
    chk("hold_lat1", 64'(cyc), 64'd80);
    chk("hold_res1", res, 64'hC000);
    @(posedge clk); #1;
    chk("hold_busy2", 64'(busy), 64'd1);
    chk("hold_done2", 64'(done), 64'd0);
    chk("hold_res_kept", res, 64'hC000);
    start = 1'b0;
    cyc = 0;
    wait_done();
    chk("hold_lat2", 64'(cyc), 64'd80);
    chk("hold_res2", res, 64'h2AAA);

    // reset mid-operation after a nan result so every output has something to clear
    op("pre_rst", -64'h8000, 64'h0, 64'h8000_0000_0000_0000, 1'b1);
    accept(64'h18000, 64'h10000);
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_nan",  64'(nan),  64'd0);
    chk("arst_res",  res,       64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("arst_nodone", 64'(nd), 64'd0);
    op("post_rst", 64'h18000, 64'h10000, 64'hC000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
